// File: rtl/rl_fifo_pkg.sv
// Shared definitions for the RAM-backed FWFT FIFO: output-buffer depth and
// the width of the total-occupancy counter.
package rl_fifo_pkg;

  // Entries held in the registered output buffer behind the RAM.
  localparam int unsigned OBUF_DEPTH = 32'd2;

  // The occupancy counter must hold 0 .. 2**abits + OBUF_DEPTH.
  // 2**abits + 2 is always below 2**(abits+2), so abits+2 bits suffice.
  function automatic int unsigned calc_cnt_bits(input int unsigned abits);
    return abits + 32'd2;
  endfunction

endpackage

// File: rtl/rl_fifo_obuf2.sv
// Two-entry registered output buffer. Absorbs RAM read returns so the
// consumer sees a valid/ready stream whose head is always in a flop.
module rl_fifo_obuf2
  import rl_fifo_pkg::*;
#(
  parameter int DBITS = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             load,
  input  logic [DBITS-1:0] load_data,
  input  logic             pop,
  output logic [1:0]       buf_cnt,
  output logic [DBITS-1:0] m_data,
  output logic             m_valid
);

  localparam logic [1:0] FULL_CNT = 2'(OBUF_DEPTH);

  logic [1:0]       cnt_r, cnt_nxt_s;
  logic [DBITS-1:0] head_r, head_nxt_s;
  logic [DBITS-1:0] tail_r, tail_nxt_s;
  logic             m_valid_r;
  logic             pop_s;

  assign pop_s = pop & (cnt_r != 2'd0);

  // Next-state of the buffer: head always holds the oldest entry.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    head_nxt_s = head_r;
    tail_nxt_s = tail_r;
    if (clr) begin
      cnt_nxt_s = 2'd0;
    end else begin
      case ({load, pop_s})
        2'b10: begin
          if (cnt_r == 2'd0) begin
            head_nxt_s = load_data;
            cnt_nxt_s  = 2'd1;
          end else if (cnt_r != FULL_CNT) begin
            tail_nxt_s = load_data;
            cnt_nxt_s  = FULL_CNT;
          end else begin
            // Read issue never lets a return land on a full buffer.
            cnt_nxt_s = cnt_r;
          end
        end
        2'b01: begin
          head_nxt_s = tail_r;
          cnt_nxt_s  = cnt_r - 2'd1;
        end
        2'b11: begin
          if (cnt_r == 2'd1) begin
            head_nxt_s = load_data;
          end else begin
            head_nxt_s = tail_r;
            tail_nxt_s = load_data;
          end
        end
        default: begin
          cnt_nxt_s = cnt_r;
        end
      endcase
    end
  end

  // Buffer registers; m_valid is registered from the next count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r     <= 2'd0;
      head_r    <= {DBITS{1'b0}};
      tail_r    <= {DBITS{1'b0}};
      m_valid_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      head_r    <= head_nxt_s;
      tail_r    <= tail_nxt_s;
      m_valid_r <= (cnt_nxt_s != 2'd0);
    end
  end

  assign buf_cnt = cnt_r;
  assign m_data  = head_r;
  assign m_valid = m_valid_r;

endmodule

// File: rtl/rl_ram_1r1w.sv
// Technology-independent 1R1W RAM: byte-enabled synchronous write,
// synchronous read with one cycle of latency. Contents are not reset.
module rl_ram_1r1w #(
  parameter int ABITS = 4,
  parameter int DBITS = 32,
  localparam int BEBITS = (DBITS + 7) / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ABITS-1:0]  waddr,
  input  logic [DBITS-1:0]  din,
  input  logic [BEBITS-1:0] be,
  input  logic              re,
  input  logic [ABITS-1:0]  raddr,
  output logic [DBITS-1:0]  dout
);

  logic [DBITS-1:0] mem_r [2**ABITS];
  logic [DBITS-1:0] bit_en_s;

  // Expand byte enables to a per-bit write mask.
  for (genvar gi = 0; gi < DBITS; gi++) begin : g_bit_en
    assign bit_en_s[gi] = be[gi/8];
  end

  // Write port: update only the enabled bits of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DBITS; i++) begin
        if (bit_en_s[i]) begin
          mem_r[waddr][i] <= din[i];
        end
      end
    end
  end

  // Read port: registered data, valid the cycle after re.
  always_ff @(posedge clk) begin
    if (re) begin
      dout <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/rl_ram_1r1w_fifo.sv
// First-word-fall-through FIFO backed by a 1R1W RAM. The RAM's one-cycle
// read latency is hidden by a two-entry output buffer, giving a capacity of
// DEPTH+2 and one push plus one pop per cycle.
module rl_ram_1r1w_fifo
  import rl_fifo_pkg::*;
#(
  parameter int ABITS     = 4,
  parameter int DBITS     = 32,
  parameter int AFULL_LVL = 2**ABITS - 2,
  localparam int CNT_BITS = calc_cnt_bits(ABITS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clr,
  input  logic [DBITS-1:0]    s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [DBITS-1:0]    m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CNT_BITS-1:0] count,
  output logic                almost_full
);

  localparam int BEBITS = (DBITS + 7) / 8;
  localparam logic [ABITS:0] DEPTH_CNT = {1'b1, {ABITS{1'b0}}};

  logic [ABITS-1:0]    wr_ptr_r, rd_ptr_r;
  logic [ABITS:0]      ram_cnt_r;
  logic                inflight_r;
  logic                almost_full_r;
  logic                push_s, pop_s, rd_issue_s;
  logic                ram_re_s;
  logic [1:0]          buf_cnt_s;
  logic [2:0]          buf_occ_s;
  logic [DBITS-1:0]    ram_dout_s;
  logic [CNT_BITS-1:0] count_s, count_nxt_s;

  // Flow control depends on registered state only, never on m_ready.
  assign s_ready    = (ram_cnt_r != DEPTH_CNT);
  assign push_s     = s_valid & s_ready & ~clr;
  assign pop_s      = m_valid & m_ready & ~clr;
  // Buffer slots that will be taken once the pending return lands.
  assign buf_occ_s  = {1'b0, buf_cnt_s} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign rd_issue_s = (ram_cnt_r != {(ABITS+1){1'b0}}) & (buf_occ_s < 3'd2) & ~clr;
  assign ram_re_s   = rd_issue_s;

  assign count_s = CNT_BITS'(ram_cnt_r) + CNT_BITS'(inflight_r) + CNT_BITS'(buf_cnt_s);
  assign count   = count_s;

  // Occupancy after this edge, used to register almost_full.
  always_comb begin
    if (clr) begin
      count_nxt_s = {CNT_BITS{1'b0}};
    end else begin
      count_nxt_s = count_s + CNT_BITS'(push_s) - CNT_BITS'(pop_s);
    end
  end

  // RAM pointers, RAM occupancy and the read-in-flight flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r   <= {ABITS{1'b0}};
      rd_ptr_r   <= {ABITS{1'b0}};
      ram_cnt_r  <= {(ABITS+1){1'b0}};
      inflight_r <= 1'b0;
    end else if (clr) begin
      wr_ptr_r   <= {ABITS{1'b0}};
      rd_ptr_r   <= {ABITS{1'b0}};
      ram_cnt_r  <= {(ABITS+1){1'b0}};
      inflight_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(ABITS-1){1'b0}}, 1'b1};
      end
      if (rd_issue_s) begin
        rd_ptr_r <= rd_ptr_r + {{(ABITS-1){1'b0}}, 1'b1};
      end
      inflight_r <= rd_issue_s;
      case ({push_s, rd_issue_s})
        2'b10:   ram_cnt_r <= ram_cnt_r + {{ABITS{1'b0}}, 1'b1};
        2'b01:   ram_cnt_r <= ram_cnt_r - {{ABITS{1'b0}}, 1'b1};
        default: ram_cnt_r <= ram_cnt_r;
      endcase
    end
  end

  // almost_full tracks the occupancy that will hold after this edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      almost_full_r <= 1'b0;
    end else begin
      almost_full_r <= (count_nxt_s >= CNT_BITS'(AFULL_LVL));
    end
  end

  assign almost_full = almost_full_r;

  rl_ram_1r1w #(
    .ABITS (ABITS),
    .DBITS (DBITS)
  ) u_ram (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .din   (s_data),
    .be    ({BEBITS{1'b1}}),
    .re    (ram_re_s),
    .raddr (rd_ptr_r),
    .dout  (ram_dout_s)
  );

  rl_fifo_obuf2 #(
    .DBITS (DBITS)
  ) u_obuf (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr),
    .load      (inflight_r),
    .load_data (ram_dout_s),
    .pop       (pop_s),
    .buf_cnt   (buf_cnt_s),
    .m_data    (m_data),
    .m_valid   (m_valid)
  );

endmodule

// File: tb/tb_rl_ram_1r1w_fifo.sv
// Self-checking bench for rl_ram_1r1w_fifo (ABITS=2, DEPTH=4, capacity 6).
// A queue-based model tracks contents and the RAM/in-flight/buffer split;
// a negedge process compares every cycle, and directed scenarios add
// hand-computed expectations.
module tb_rl_ram_1r1w_fifo;

  localparam int ABITS = 2;
  localparam int DBITS = 32;
  localparam int DEPTH = 4;
  localparam int AFULL = 2;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             clr = 1'b0;
  logic [DBITS-1:0] s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [DBITS-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [ABITS+1:0] count;
  logic             almost_full;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  // Model state: FIFO contents plus where the entries sit.
  logic [DBITS-1:0] q[$];
  int n_ram = 0;
  int n_fly = 0;
  int n_buf = 0;

  rl_ram_1r1w_fifo #(
    .ABITS     (ABITS),
    .DBITS     (DBITS),
    .AFULL_LVL (AFULL)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .clr         (clr),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    n_ram = 0;
    n_fly = 0;
    n_buf = 0;
  endtask

  // Apply one clock edge worth of the FIFO rules to the model.
  task automatic model_edge(input logic v, input logic [DBITS-1:0] d, input logic r, input logic c);
    int push;
    int pop;
    int issue;
    if (!rstn || c) begin
      model_reset();
    end else begin
      push  = (v && n_ram != DEPTH) ? 1 : 0;
      pop   = (r && n_buf > 0) ? 1 : 0;
      issue = (n_ram > 0 && (n_buf + n_fly - pop) < 2) ? 1 : 0;
      if (pop != 0) void'(q.pop_front());
      if (push != 0) q.push_back(d);
      n_buf = n_buf - pop + n_fly;
      n_fly = issue;
      n_ram = n_ram + push - issue;
    end
  endtask

  // Drive inputs for one cycle, let the edge happen, advance the model.
  task automatic step(input logic v, input logic [DBITS-1:0] d, input logic r, input logic c);
    s_valid = v;
    s_data  = d;
    m_ready = r;
    clr     = c;
    @(posedge clk);
    model_edge(v, d, r, c);
    #1;
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("s_ready", s_ready, (n_ram != DEPTH));
      chk("m_valid", m_valid, (n_buf > 0));
      if (n_buf > 0) chk("m_data", m_data, q[0]);
      chk("count", count, q.size());
      chk("almost_full", almost_full, (q.size() >= AFULL));
    end
  end

  initial begin
    int k;
    // Reset state, observed without any clock edge.
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_count", count, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
    rstn   = 1'b1;
    cmp_en = 1'b1;

    // 1: single push latency on an empty FIFO.
    step(1'b1, 32'hA5, 1'b1, 1'b0);
    chk("t1_re_c1", dut.ram_re_s, 1);
    chk("t1_mv_c1", m_valid, 0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t1_mv_c2", m_valid, 0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t1_mv_c3", m_valid, 1);
    chk("t1_md_c3", m_data, 32'hA5);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t1_cnt_c4", count, 0);

    // 2: fill with m_ready low, 6 accepted, then gap-free drain in order.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'(i), 1'b0, 1'b0);
      if (i == 5) begin
        chk("t2_sready_after6", s_ready, 0);
        chk("t2_cnt_after6", count, 6);
      end
    end
    chk("t2_cnt_full", count, 6);
    for (int i = 0; i < 6; i++) begin
      chk("t2_drain_mv", m_valid, 1);
      chk("t2_drain_md", m_data, 32'(i));
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("t2_cnt_empty", count, 0);

    // 3: 50 cycles of simultaneous push/pop; occupancy settles at 3.
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0);
    end
    chk("t3_cnt_steady", count, 3);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    // 4: full FIFO, push and pop together: push refused.
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 32'h40 + 32'(i), 1'b0, 1'b0);
    chk("t4_cnt_full", count, 6);
    chk("t4_sready_full", s_ready, 0);
    step(1'b1, 32'hEE, 1'b1, 1'b0);
    chk("t4_cnt_after", count, 5);
    chk("t4_sready_after", s_ready, 1);
    chk("t4_md_after", m_data, 32'h41);

    // 5: clr with a read in flight; a later push is the first output.
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
    chk("t5_cnt3", count, 3);
    chk("t5_inflight", dut.inflight_r, 1);
    step(1'b1, 32'hDD, 1'b1, 1'b1);
    chk("t5_clr_cnt", count, 0);
    chk("t5_clr_mv", m_valid, 0);
    chk("t5_clr_sready", s_ready, 1);
    step(1'b1, 32'h11, 1'b0, 1'b0);
    k = 0;
    while (!m_valid && k < 8) begin
      step(1'b0, 32'h0, 1'b0, 1'b0);
      k++;
    end
    chk("t5_first_mv", m_valid, 1);
    chk("t5_first_md", m_data, 32'h11);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic: scarce pops first (reaches full), then heavy pops.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom,
           (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 63) == 0));
    end

    // 6: asynchronous reset mid-stream, then normal operation from empty.
    for (int i = 0; i < 10; i++) step(1'b1, 32'h2000 + 32'(i), 1'b1, 1'b0);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("t6_mv", m_valid, 0);
    chk("t6_md", m_data, 0);
    chk("t6_cnt", count, 0);
    chk("t6_af", almost_full, 0);
    chk("t6_sready", s_ready, 1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step(1'b1, 32'h77, 1'b1, 1'b0);
    k = 0;
    while (!m_valid && k < 8) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      k++;
    end
    chk("t6_post_mv", m_valid, 1);
    chk("t6_post_md", m_data, 32'h77);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
